// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RV32I load/store size codes, FSM states, memory depth.
// Lane alignment helper used by the top-level decode.
package lsu_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_e;

  // Halfwords drop bit 0 and words drop both low bits; bytes keep their lane.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   align_offset = {off[1], 1'b0};
      2'b10:   align_offset = 2'b00;
      default: align_offset = off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword of a
// loaded word, and builds the store-merge word from the read-modify-write buffer.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] buf_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    ldata_o  = '0;
    merged_o = buf_i;
    laneByte = word_i[{offset_i, 3'b000} +: 8];
    laneHalf = word_i[{offset_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B: begin
        ldata_o = {{24{laneByte[7]}}, laneByte};
        merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H: begin
        ldata_o = {{16{laneHalf[15]}}, laneHalf};
        merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
      end
      F3_W:    ldata_o = word_i;
      F3_BU:   ldata_o = {24'h0, laneByte};
      F3_HU:   ldata_o = {16'h0, laneHalf};
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time against a single-port word memory, with
// read-modify-write for SB/SH. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;

  logic          illegal, misaligned, accessErr;
  logic [1:0]    offset;
  logic [31:0]   laneData, mergedWord;

  // Only the index bits are kept, so out-of-range addresses alias naturally.
  assign mem_addr  = {{(30 - AW){1'b0}}, addr_q[AW+1:2], 2'b00};
  assign offset    = align_offset(funct3_q[1:0], addr_q[1:0]);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    illegal = we_q ? (funct3_q > F3_W)
                   : !(funct3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    accessErr = illegal || misaligned;
  end

  lsu_lane u_lane (
    .funct3_i (funct3_q),
    .offset_i (offset),
    .word_i   (mem_rdata),
    .buf_i    (buf_q),
    .wdata_i  (wdata_q[15:0]),
    .ldata_o  (laneData),
    .merged_o (mergedWord)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[AW+1:0];
          wdata_d  = req_wdata;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
        if (accessErr) begin
          err_d = 1'b1;
        end else if (!we_q) begin
          mem_read = 1'b1;
          rdata_d  = laneData;
        end else if (funct3_q == F3_W) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
        end else begin
          mem_read = 1'b1;
          buf_d    = mem_rdata;
          state_d  = MERGE;
        end
      end
      MERGE: begin
        mem_write = 1'b1;
        mem_wdata = mergedWord;
        state_d   = RESP;
      end
      RESP: begin
        // rsp_valid is registered, so it rises one cycle after entering RESP.
        if (valid_q && rsp_ready) begin
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

endmodule
